// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment vector type, special glyphs and the hex font.
// Bit order is {g,f,e,d,c,b,a}, active-high (1 = segment lit).
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_DASH  = 7'b1000000;
  localparam seg_t SEG_BLANK = 7'b0000000;

  localparam seg_t HEX_GLYPH [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1100111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

endpackage

// File: rtl/seg7_glyph.sv
// Combinational single-digit decoder: hex nibble plus invalid/blank qualifiers to
// an active-high segment vector. Invalid wins over blank, blank wins over the glyph.
module seg7_glyph
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  input  logic       n_valid,
  input  logic       blank,
  output seg_t       seg
);

  // priority decode of one digit
  always_comb begin
    seg = SEG_BLANK;
    if (n_valid) begin
      seg = SEG_DASH;
    end else if (blank) begin
      seg = SEG_BLANK;
    end else begin
      seg = HEX_GLYPH[hex];
    end
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed DIGITS-wide 7-segment driver with load-captured shadow data,
// leading-zero blanking, pin polarity control and a frame-wrap tick.
module seven_seg_scanner
  import seg7_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int BLANK_LZ       = 1,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     n_valid,
  input  logic                  load,
  output logic [6:0]            sseg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_tick
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PW-1:0]     PRE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
  // XOR masks that also serve as the physical "off" levels
  localparam seg_t              SEG_MASK = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [DIGITS-1:0] AN_MASK  = (AN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [PW-1:0]         prescale;
  logic [IW-1:0]         index;
  logic [4*DIGITS-1:0]   shadow_value;
  logic [DIGITS-1:0]     shadow_nv;
  logic                  loaded;
  logic                  tick;

  logic [3:0]            sel_hex;
  logic                  sel_nv;
  logic                  sel_blank;
  logic [DIGITS-1:0]     blank_vec;
  logic [DIGITS-1:0]     an_onehot;
  seg_t                  glyph;
  seg_t                  seg_next;
  logic [DIGITS-1:0]     an_next;

  assign tick = (prescale == PRE_LAST);

  // prescaler, scan index and frame-wrap pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescale   <= '0;
      index      <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      if (tick) begin
        prescale <= '0;
        if (index == IDX_LAST) begin
          index      <= '0;
          frame_tick <= 1'b1;
        end else begin
          index <= index + IW'(1);
        end
      end else begin
        prescale <= prescale + PW'(1);
      end
    end
  end

  // shadow capture; independent of the scan so a load never disturbs timing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_value <= '0;
      shadow_nv    <= '0;
      loaded       <= 1'b0;
    end else if (load) begin
      shadow_value <= value;
      shadow_nv    <= n_valid;
      loaded       <= 1'b1;
    end else begin
      shadow_value <= shadow_value;
      shadow_nv    <= shadow_nv;
      loaded       <= loaded;
    end
  end

  // leading-zero chain: a digit blanks only if it and everything above it is a valid zero
  always_comb begin
    logic zero_run;
    zero_run  = 1'b1;
    blank_vec = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run     = zero_run & (shadow_value[4*i +: 4] == 4'h0) & ~shadow_nv[i];
      blank_vec[i] = (BLANK_LZ != 0) & zero_run;
    end
  end

  // select the active digit's data and build the one-hot anode vector
  always_comb begin
    sel_hex   = 4'h0;
    sel_nv    = 1'b0;
    sel_blank = 1'b0;
    an_onehot = '0;
    for (int i = 0; i < DIGITS; i++) begin
      an_onehot[i] = (index == IW'(i));
      sel_hex      = (index == IW'(i)) ? shadow_value[4*i +: 4] : sel_hex;
      sel_nv       = (index == IW'(i)) ? shadow_nv[i]           : sel_nv;
      sel_blank    = (index == IW'(i)) ? blank_vec[i]           : sel_blank;
    end
  end

  seg7_glyph u_glyph (
    .hex     (sel_hex),
    .n_valid (sel_nv),
    .blank   (sel_blank),
    .seg     (glyph)
  );

  // polarity applied before the register so reset already drives the off level
  always_comb begin
    seg_next = SEG_MASK;
    if (loaded) begin
      seg_next = glyph ^ SEG_MASK;
    end else begin
      seg_next = SEG_BLANK ^ SEG_MASK;
    end
    an_next = an_onehot ^ AN_MASK;
  end

  // output register: anode and segments move together on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sseg <= SEG_MASK;
      an   <= AN_MASK;
    end else begin
      sseg <= seg_next;
      an   <= an_next;
    end
  end

endmodule
